// File: rtl/armleocpu_operand_fetch.sv
// Operand-fetch stage: reads both source registers on accept, holds one instruction,
// and tracks writeback hits so the delivered operands always reflect the latest value.
module armleocpu_operand_fetch (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,

    output logic        rs1_read,
    output logic [4:0]  rs1_addr,
    input  logic [31:0] rs1_rdata,
    output logic        rs2_read,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs2_rdata,

    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_rd_wdata,
    input  logic        wb_rd_write,

    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,

    input  logic        kill
);

    logic        o_valid_q, o_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  a1_q, a1_d;
    logic [4:0]  a2_q, a2_d;
    logic        sel_1_q, sel_1_d;
    logic        sel_2_q, sel_2_d;
    logic [31:0] byp_1_q, byp_1_d;
    logic [31:0] byp_2_q, byp_2_d;
    logic        accept_s;

    // A writeback to x0 never counts as a hit.
    function automatic logic wb_hit(input logic wr, input logic [4:0] wa, input logic [4:0] a);
        return wr && (wa != 5'd0) && (wa == a);
    endfunction

    // Handshake and register-file read requests.
    always_comb begin
        i_ready  = rst_n && !kill && (!o_valid_q || o_ready);
        accept_s = i_valid && i_ready;
        rs1_addr = i_instr[19:15];
        rs2_addr = i_instr[24:20];
        rs1_read = accept_s;
        rs2_read = accept_s;
    end

    // Next-state: load on accept, otherwise snoop writebacks into the held operands.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        sel_1_d = sel_1_q;
        sel_2_d = sel_2_q;
        byp_1_d = byp_1_q;
        byp_2_d = byp_2_q;

        if (accept_s) begin
            instr_d = i_instr;
            pc_d    = i_pc;
            a1_d    = rs1_addr;
            a2_d    = rs2_addr;
            if (wb_hit(wb_rd_write, wb_rd_addr, rs1_addr)) begin
                sel_1_d = 1'b1;
                byp_1_d = wb_rd_wdata;
            end else begin
                sel_1_d = 1'b0;
            end
            if (wb_hit(wb_rd_write, wb_rd_addr, rs2_addr)) begin
                sel_2_d = 1'b1;
                byp_2_d = wb_rd_wdata;
            end else begin
                sel_2_d = 1'b0;
            end
        end else if (o_valid_q) begin
            if (wb_hit(wb_rd_write, wb_rd_addr, a1_q)) begin
                sel_1_d = 1'b1;
                byp_1_d = wb_rd_wdata;
            end else begin
                sel_1_d = sel_1_q;
            end
            if (wb_hit(wb_rd_write, wb_rd_addr, a2_q)) begin
                sel_2_d = 1'b1;
                byp_2_d = wb_rd_wdata;
            end else begin
                sel_2_d = sel_2_q;
            end
        end else begin
            sel_1_d = sel_1_q;
            sel_2_d = sel_2_q;
        end

        if (kill) begin
            o_valid_d = 1'b0;
        end else if (accept_s) begin
            o_valid_d = 1'b1;
        end else if (o_ready) begin
            o_valid_d = 1'b0;
        end else begin
            o_valid_d = o_valid_q;
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            instr_q   <= 32'd0;
            pc_q      <= 32'd0;
            a1_q      <= 5'd0;
            a2_q      <= 5'd0;
            sel_1_q   <= 1'b0;
            sel_2_q   <= 1'b0;
            byp_1_q   <= 32'd0;
            byp_2_q   <= 32'd0;
        end else begin
            o_valid_q <= o_valid_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            sel_1_q   <= sel_1_d;
            sel_2_q   <= sel_2_d;
            byp_1_q   <= byp_1_d;
            byp_2_q   <= byp_2_d;
        end
    end

    // Operand selection: x0 reads as zero, a captured writeback wins over the register file.
    always_comb begin
        o_valid = o_valid_q;
        o_instr = instr_q;
        o_pc    = pc_q;
        if (a1_q == 5'd0) begin
            o_rs1_data = 32'd0;
        end else if (sel_1_q) begin
            o_rs1_data = byp_1_q;
        end else begin
            o_rs1_data = rs1_rdata;
        end
        if (a2_q == 5'd0) begin
            o_rs2_data = 32'd0;
        end else if (sel_2_q) begin
            o_rs2_data = byp_2_q;
        end else begin
            o_rs2_data = rs2_rdata;
        end
    end

endmodule

// File: tb/tb_armleocpu_operand_fetch.sv
// Bench for armleocpu_operand_fetch: a register file with one-cycle reads, plus a
// reference model that expects every delivered operand to equal the current architectural value.
module tb_armleocpu_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_ready;
    logic [31:0] i_instr, i_pc;
    logic        rs1_read, rs2_read;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_rdata, rs2_rdata;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_wdata;
    logic        wb_rd_write;
    logic        o_valid, o_ready;
    logic [31:0] o_instr, o_pc, o_rs1_data, o_rs2_data;
    logic        kill;

    logic [31:0] regs [32];
    int          checks = 0;
    int          errors = 0;

    logic        mv;
    logic [31:0] minstr, mpc;

    localparam logic [31:0] ADD_X1_X5_X6 = {7'd0, 5'd6, 5'd5, 3'd0, 5'd1, 7'b0110011};
    localparam logic [31:0] ADD_X2_X0_X5 = {7'd0, 5'd5, 5'd0, 3'd0, 5'd2, 7'b0110011};

    armleocpu_operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(i_ready), .i_instr(i_instr), .i_pc(i_pc),
        .rs1_read(rs1_read), .rs1_addr(rs1_addr), .rs1_rdata(rs1_rdata),
        .rs2_read(rs2_read), .rs2_addr(rs2_addr), .rs2_rdata(rs2_rdata),
        .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata), .wb_rd_write(wb_rd_write),
        .o_valid(o_valid), .o_ready(o_ready), .o_instr(o_instr), .o_pc(o_pc),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
        .kill(kill)
    );

    always #5 clk = ~clk;

    // Register file: read data is registered and holds while no read is issued.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'(i) * 32'h0101_0101;
            rs1_rdata <= 32'd0;
            rs2_rdata <= 32'd0;
        end else begin
            if (rs1_read) rs1_rdata <= regs[rs1_addr];
            if (rs2_read) rs2_rdata <= regs[rs2_addr];
            if (wb_rd_write && wb_rd_addr != 5'd0) regs[wb_rd_addr] <= wb_rd_wdata;
        end
    end

    function automatic logic [31:0] arch_val(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : regs[a];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check, then advance the model at posedge.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic k, input logic ordy,
                        input logic wbw, input logic [4:0] wba, input logic [31:0] wbd);
        logic rdy_e, acc_e;
        @(negedge clk);
        i_valid = iv; i_instr = ins; i_pc = pc; kill = k; o_ready = ordy;
        wb_rd_write = wbw; wb_rd_addr = wba; wb_rd_wdata = wbd;
        #1;
        rdy_e = !k && (!mv || ordy);
        acc_e = iv && rdy_e;
        check_eq("i_ready", {31'd0, i_ready}, {31'd0, rdy_e});
        check_eq("rs1_read", {31'd0, rs1_read}, {31'd0, acc_e});
        check_eq("rs2_read", {31'd0, rs2_read}, {31'd0, acc_e});
        check_eq("rs1_addr", {27'd0, rs1_addr}, {27'd0, ins[19:15]});
        check_eq("rs2_addr", {27'd0, rs2_addr}, {27'd0, ins[24:20]});
        check_eq("o_valid", {31'd0, o_valid}, {31'd0, mv});
        if (mv) begin
            check_eq("o_instr", o_instr, minstr);
            check_eq("o_pc", o_pc, mpc);
            check_eq("o_rs1_data", o_rs1_data, arch_val(minstr[19:15]));
            check_eq("o_rs2_data", o_rs2_data, arch_val(minstr[24:20]));
        end
        @(posedge clk);
        if (k) mv = 1'b0;
        else if (acc_e) begin mv = 1'b1; minstr = ins; mpc = pc; end
        else if (ordy) mv = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        mv = 1'b0; minstr = 32'd0; mpc = 32'd0;
        rst_n = 1'b0; i_valid = 1'b1; i_instr = ADD_X1_X5_X6; i_pc = 32'h40;
        kill = 1'b0; o_ready = 1'b1;
        wb_rd_write = 1'b0; wb_rd_addr = 5'd0; wb_rd_wdata = 32'd0;
        @(posedge clk); @(posedge clk); #2;
        check_eq("rst_o_valid", {31'd0, o_valid}, 32'd0);
        check_eq("rst_i_ready", {31'd0, i_ready}, 32'd0);
        check_eq("rst_rs1_read", {31'd0, rs1_read}, 32'd0);
        check_eq("rst_rs2_read", {31'd0, rs2_read}, 32'd0);
        check_eq("rst_o_instr", o_instr, 32'd0);
        check_eq("rst_o_pc", o_pc, 32'd0);
        rst_n = 1'b1;

        // First edge after release accepts; load x5/x6 through the writeback port.
        step(1'b1, 32'h0000_0013, 32'h80, 1'b0, 1'b1, 1'b1, 5'd5, 32'h11);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h22);
        step(1'b1, ADD_X1_X5_X6, 32'h100, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        check_eq("basic_valid", {31'd0, o_valid}, 32'd1);
        check_eq("basic_rs1", o_rs1_data, 32'h11);
        check_eq("basic_rs2", o_rs2_data, 32'h22);
        check_eq("basic_pc", o_pc, 32'h100);

        // Same-cycle bypass on accept.
        step(1'b1, ADD_X1_X5_X6, 32'h104, 1'b0, 1'b1, 1'b1, 5'd5, 32'hAB);
        #1;
        check_eq("samecyc_rs1", o_rs1_data, 32'hAB);

        // Stall with two writebacks to x6; no reads while stalled.
        step(1'b1, ADD_X2_X0_X5, 32'h108, 1'b0, 1'b0, 1'b1, 5'd6, 32'h33);
        step(1'b1, ADD_X2_X0_X5, 32'h108, 1'b0, 1'b0, 1'b1, 5'd6, 32'h44);
        step(1'b1, ADD_X2_X0_X5, 32'h108, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        check_eq("stall_rs2", o_rs2_data, 32'h44);
        check_eq("stall_pc", o_pc, 32'h104);

        // x0 source while writeback targets x0.
        step(1'b1, ADD_X2_X0_X5, 32'h10C, 1'b0, 1'b1, 1'b1, 5'd0, 32'hFF);
        #1;
        check_eq("x0_rs1", o_rs1_data, 32'd0);

        // Back-to-back with a kill in the second cycle.
        step(1'b1, ADD_X1_X5_X6, 32'h200, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b1, ADD_X1_X5_X6, 32'h204, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        #1;
        check_eq("kill_drop", {31'd0, o_valid}, 32'd0);
        step(1'b1, ADD_X2_X0_X5, 32'h208, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b1, ADD_X1_X5_X6, 32'h20C, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);

        // Randomized traffic over a small register window to force address collisions.
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            r[19:15] = 5'($urandom_range(0, 3));
            r[24:20] = 5'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, r, $urandom, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 3)), $urandom);
        end

        // Asynchronous reset between edges while holding an instruction.
        step(1'b1, ADD_X1_X5_X6, 32'h300, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        #2;
        check_eq("pre_rst_valid", {31'd0, o_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", {31'd0, o_valid}, 32'd0);
        check_eq("async_rst_ready", {31'd0, i_ready}, 32'd0);
        check_eq("async_rst_read", {31'd0, rs1_read}, 32'd0);
        mv = 1'b0;
        @(posedge clk); #2;
        check_eq("async_rst_pc", o_pc, 32'd0);
        rst_n = 1'b1;
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b1, ADD_X1_X5_X6, 32'h400, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/armleocpu_operand_fetch.md
ARMLEOCPU_OPERAND_FETCH -- requirements
Module: armleocpu_operand_fetch

Interface
REQ-001 The block SHALL have a single clock `clk`, and all state SHALL be updated on its rising edge.
REQ-002 The block SHALL have reset `rst_n`, asynchronous and active-low.
REQ-003 Upstream ports SHALL be:
- i_valid, input, 1: instruction available.
- i_ready, output, 1: stage can accept.
- i_instr, input, 32: RV32 instruction.
- i_pc, input, 32: its PC.
REQ-004 Register-file read ports SHALL be:
- rs1_read, output, 1; rs1_addr, output, 5; rs1_rdata, input, 32.
- rs2_read, output, 1; rs2_addr, output, 5; rs2_rdata, input, 32.
- Read data arrives the cycle after read=1 and holds while read=0.
REQ-005 Writeback snoop ports SHALL be wb_rd_addr (input, 5), wb_rd_wdata (input, 32) and wb_rd_write (input, 1), the same signals that drive the register-file write port.
REQ-006 Downstream ports SHALL be:
- o_valid, output, 1; o_ready, input, 1.
- o_instr, output, 32; o_pc, output, 32.
- o_rs1_data, output, 32; o_rs2_data, output, 32.
REQ-007 The block SHALL have kill, input, 1: flush of the stage contents and of any same-cycle accept.

Function
REQ-008 i_ready SHALL equal !kill && (!o_valid || o_ready), combinationally.
REQ-009 "Accept" SHALL mean i_valid && i_ready, and it SHALL be the only event that loads the stage.
REQ-010 rs1_addr SHALL equal i_instr[19:15] and rs2_addr SHALL equal i_instr[24:20] at all times.
REQ-011 rs1_read and rs2_read SHALL both equal accept, so that no read is issued while stalled or killed.
REQ-012 On accept, the stage SHALL capture i_instr, i_pc, and both source addresses (a1_q, a2_q), and SHALL set o_valid=1 in the next cycle.
REQ-013 o_valid SHALL behave as follows:
- cleared next cycle when kill=1;
- else cleared when o_ready=1 and there is no accept;
- else held.
REQ-014 Back-to-back operation SHALL be supported: o_valid && o_ready && i_valid SHALL hand off and reload in the same cycle with no bubble.
REQ-015 Each operand n SHALL have a bypass flag sel_n and a bypass register byp_n.
REQ-016 On accept, sel_n and byp_n SHALL update as follows:
- if wb_rd_write && wb_rd_addr != 0 && wb_rd_addr == the new source address, sel_n<=1 and byp_n<=wb_rd_wdata;
- otherwise sel_n<=0.
REQ-017 While o_valid=1 and there is no accept, each wb write with wb_rd_addr != 0 and wb_rd_addr == an_q SHALL set sel_n<=1 and byp_n<=wb_rd_wdata.
REQ-018 o_rsn_data SHALL be selected combinationally:
- 0 if an_q == 0;
- else byp_n if sel_n=1;
- else rsn_rdata.
REQ-019 o_instr, o_pc and o_rs*_data SHALL be stable while o_valid && !o_ready, except for a bypass update under REQ-017.
REQ-020 When kill and i_valid are asserted together, the instruction SHALL not be accepted, no read SHALL be issued, and o_valid SHALL be 0 next cycle.
REQ-021 Writes with wb_rd_addr == 0 SHALL never set a bypass flag.
REQ-022 Decode of the opcode SHALL NOT affect reads: both operands SHALL always be read, including for U/J-type instructions.
REQ-023 All outputs SHALL be driven (no X) whenever o_valid=1.

Reset
REQ-024 While rst_n=0, the block SHALL force o_valid=0, sel_1=sel_2=0, and byp_1, byp_2, o_instr, o_pc, a1_q and a2_q to 0.
REQ-025 While rst_n=0, i_ready SHALL be 0, and rs1_read and rs2_read SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard the held instruction, with no output handshake after release.
REQ-027 Following reset release, the first accept SHALL be possible in the first clock edge in which rst_n=1.

Verification
REQ-028 Basic: regfile x5=0x11, x6=0x22; send add x1,x5,x6 at pc 0x100 -> the next cycle shows o_valid=1, o_rs1_data=0x11, o_rs2_data=0x22, o_pc=0x100.
REQ-029 Same-cycle bypass: the accept reading x5 coincides with a wb write of x5=0xAB -> o_rs1_data=0xAB (not the stale value).
REQ-030 Stall bypass: o_ready=0 for 3 cycles, and wb writes x6=0x33 and then x6=0x44 during the stall -> o_rs2_data=0x44 when the handshake completes, and rs*_read=0 throughout the stall.
REQ-031 x0 handling: an instruction with rs1=x0 while wb writes addr 0 with data 0xFF -> o_rs1_data=0.
REQ-032 Throughput and kill: 4 back-to-back instructions with o_ready=1 -> 4 outputs in consecutive cycles; kill asserted in cycle 2 -> that slot is dropped and o_valid=0 the next cycle.
REQ-033 Async reset: rst_n pulled low between clock edges while o_valid=1 -> o_valid=0 immediately, with no handshake until a new accept.
